// File: rtl/cdb_arbiter.sv
// Completion-bus arbiter: one holding register per functional unit, rotating-priority
// selection of up to three results per cycle onto a registered 3-wide broadcast.
module cdb_arbiter #(
    parameter int          NUM_FU  = 5,
    parameter int          PR      = 6,
    parameter int          XLEN    = 32,
    parameter logic [PR-1:0] ZERO_PR = '0
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        squash,
    input  logic [NUM_FU-1:0]           fu_valid,
    input  logic [NUM_FU-1:0][PR-1:0]   fu_tag,
    input  logic [NUM_FU-1:0][XLEN-1:0] fu_data,
    output logic [NUM_FU-1:0]           fu_ready,
    output logic [PR-1:0]               cdb_t0,
    output logic [PR-1:0]               cdb_t1,
    output logic [PR-1:0]               cdb_t2,
    output logic [2:0][XLEN-1:0]        cdb_data,
    output logic [1:0]                  cdb_count
);

    localparam int PW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic [NUM_FU-1:0]           hold_valid;
    logic [NUM_FU-1:0][PR-1:0]   hold_tag;
    logic [NUM_FU-1:0][XLEN-1:0] hold_data;
    logic [PW-1:0]               rr_ptr;

    logic [NUM_FU-1:0]           grant;
    logic [2:0][PW-1:0]          sel;
    logic [2:0]                  slot_used;
    logic [1:0]                  slot_cnt;
    logic [PW-1:0]               last_idx;
    logic [PW:0]                 sum;
    logic [PW-1:0]               idx;
    logic [2:0][PR-1:0]          cdb_tag;

    // Scan from rr_ptr with wraparound; the first three occupied holds fill slots 0..2.
    always_comb begin
        grant     = '0;
        sel       = '0;
        slot_used = '0;
        slot_cnt  = '0;
        last_idx  = rr_ptr;
        sum       = '0;
        idx       = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            sum = {1'b0, rr_ptr} + (PW+1)'(k);
            if (sum >= (PW+1)'(NUM_FU))
                sum = sum - (PW+1)'(NUM_FU);
            idx = sum[PW-1:0];
            if (hold_valid[idx] && (slot_cnt != 2'd3)) begin
                grant[idx]          = 1'b1;
                sel[slot_cnt]       = idx;
                slot_used[slot_cnt] = 1'b1;
                slot_cnt            = slot_cnt + 2'd1;
                last_idx            = idx;
            end
        end
    end

    assign fu_ready = ~hold_valid | grant;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold_valid <= '0;
            hold_tag   <= '0;
            hold_data  <= '0;
            rr_ptr     <= '0;
            cdb_tag    <= {3{ZERO_PR}};
            cdb_data   <= '0;
            cdb_count  <= '0;
        end else if (squash) begin
            hold_valid <= '0;
            cdb_tag    <= {3{ZERO_PR}};
            cdb_data   <= '0;
            cdb_count  <= '0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (grant[i])
                    hold_valid[i] <= 1'b0;
                // Zero-tag results are accepted but never held.
                if (fu_valid[i] && fu_ready[i] && (fu_tag[i] != ZERO_PR)) begin
                    hold_valid[i] <= 1'b1;
                    hold_tag[i]   <= fu_tag[i];
                    hold_data[i]  <= fu_data[i];
                end
            end
            for (int s = 0; s < 3; s++) begin
                if (slot_used[s]) begin
                    cdb_tag[s]  <= hold_tag[sel[s]];
                    cdb_data[s] <= hold_data[sel[s]];
                end else begin
                    cdb_tag[s]  <= ZERO_PR;
                    cdb_data[s] <= '0;
                end
            end
            cdb_count <= slot_cnt;
            if (slot_cnt != 2'd0) begin
                if (last_idx == PW'(NUM_FU - 1))
                    rr_ptr <= '0;
                else
                    rr_ptr <= last_idx + PW'(1);
            end
        end
    end

    assign cdb_t0 = cdb_tag[0];
    assign cdb_t1 = cdb_tag[1];
    assign cdb_t2 = cdb_tag[2];

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, latency, overflow/fairness, zero tag,
// back-to-back streaming, squash and asynchronous mid-operation reset.
module tb_cdb_arbiter;

    localparam int NUM_FU = 5;
    localparam int PR     = 6;
    localparam int XLEN   = 32;

    logic                        clock;
    logic                        reset;
    logic                        squash;
    logic [NUM_FU-1:0]           fu_valid;
    logic [NUM_FU-1:0][PR-1:0]   fu_tag;
    logic [NUM_FU-1:0][XLEN-1:0] fu_data;
    logic [NUM_FU-1:0]           fu_ready;
    logic [PR-1:0]               cdb_t0;
    logic [PR-1:0]               cdb_t1;
    logic [PR-1:0]               cdb_t2;
    logic [2:0][XLEN-1:0]        cdb_data;
    logic [1:0]                  cdb_count;

    int asserts_evaluated = 0;
    int failures          = 0;

    cdb_arbiter #(
        .NUM_FU (NUM_FU),
        .PR     (PR),
        .XLEN   (XLEN),
        .ZERO_PR(6'd0)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .squash   (squash),
        .fu_valid (fu_valid),
        .fu_tag   (fu_tag),
        .fu_data  (fu_data),
        .fu_ready (fu_ready),
        .cdb_t0   (cdb_t0),
        .cdb_t1   (cdb_t1),
        .cdb_t2   (cdb_t2),
        .cdb_data (cdb_data),
        .cdb_count(cdb_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        asserts_evaluated++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        fu_valid = '0;
        fu_tag   = '0;
        fu_data  = '0;
        squash   = 1'b0;
    endtask

    task automatic load_all(input int base);
        for (int i = 0; i < NUM_FU; i++) begin
            fu_valid[i] = 1'b1;
            fu_tag[i]   = PR'(base + i);
            fu_data[i]  = XLEN'(32'h100 + base + i);
        end
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        check("reset_t0", 64'(cdb_t0), 64'd0);
        check("reset_count", 64'(cdb_count), 64'd0);
        check("reset_ready", 64'(fu_ready), 64'h1f);
        reset = 1'b0;
        tick();

        // Overflow: five results at once with rr_ptr = 0.
        load_all(1);
        tick();
        idle_inputs();
        check("ovf_ready_held", 64'(fu_ready), 64'h07);
        check("ovf_lat_count", 64'(cdb_count), 64'd0);
        tick();
        check("ovf1_t0", 64'(cdb_t0), 64'd1);
        check("ovf1_t1", 64'(cdb_t1), 64'd2);
        check("ovf1_t2", 64'(cdb_t2), 64'd3);
        check("ovf1_d0", 64'(cdb_data[0]), 64'h101);
        check("ovf1_d2", 64'(cdb_data[2]), 64'h103);
        check("ovf1_count", 64'(cdb_count), 64'd3);
        tick();
        check("ovf2_t0", 64'(cdb_t0), 64'd4);
        check("ovf2_t1", 64'(cdb_t1), 64'd5);
        check("ovf2_t2", 64'(cdb_t2), 64'd0);
        check("ovf2_d1", 64'(cdb_data[1]), 64'h105);
        check("ovf2_d2", 64'(cdb_data[2]), 64'h0);
        check("ovf2_count", 64'(cdb_count), 64'd2);
        // rr_ptr should now be back at 0: a second burst starts with FU0.
        load_all(11);
        tick();
        idle_inputs();
        tick();
        check("rr_t0", 64'(cdb_t0), 64'd11);
        check("rr_t1", 64'(cdb_t1), 64'd12);
        check("rr_t2", 64'(cdb_t2), 64'd13);
        tick();
        check("rr2_t0", 64'(cdb_t0), 64'd14);
        check("rr2_count", 64'(cdb_count), 64'd2);
        tick();
        check("rr_idle_count", 64'(cdb_count), 64'd0);
        check("rr_idle_t0", 64'(cdb_t0), 64'd0);

        // Single result from FU2.
        fu_valid[2] = 1'b1;
        fu_tag[2]   = 6'd7;
        fu_data[2]  = 32'hDEAD;
        tick();
        idle_inputs();
        check("single_lat_count", 64'(cdb_count), 64'd0);
        tick();
        check("single_t0", 64'(cdb_t0), 64'd7);
        check("single_d0", 64'(cdb_data[0]), 64'hDEAD);
        check("single_t1", 64'(cdb_t1), 64'd0);
        check("single_count", 64'(cdb_count), 64'd1);
        tick();
        check("single_idle_count", 64'(cdb_count), 64'd0);
        check("single_idle_t0", 64'(cdb_t0), 64'd0);
        check("single_idle_d0", 64'(cdb_data[0]), 64'h0);

        // Zero tag is consumed and never broadcast.
        fu_valid[0] = 1'b1;
        fu_tag[0]   = 6'd0;
        fu_data[0]  = 32'h55;
        check("zero_ready_pre", 64'(fu_ready[0]), 64'd1);
        tick();
        idle_inputs();
        check("zero_ready_post", 64'(fu_ready[0]), 64'd1);
        tick();
        check("zero_count", 64'(cdb_count), 64'd0);
        check("zero_d0", 64'(cdb_data[0]), 64'h0);

        // Back-to-back stream on FU1.
        fu_valid[1] = 1'b1;
        fu_tag[1]   = 6'd20;
        fu_data[1]  = 32'h200;
        tick();
        check("b2b_ready", 64'(fu_ready[1]), 64'd1);
        fu_tag[1]  = 6'd21;
        fu_data[1] = 32'h201;
        for (int n = 1; n <= 10; n++) begin
            tick();
            check("b2b_t0", 64'(cdb_t0), 64'(20 + n - 1));
            check("b2b_count", 64'(cdb_count), 64'd1);
            check("b2b_ready_n", 64'(fu_ready[1]), 64'd1);
            fu_tag[1]  = PR'(20 + n + 1);
            fu_data[1] = XLEN'(32'h200 + n + 1);
        end
        idle_inputs();
        tick();
        check("b2b_last_t0", 64'(cdb_t0), 64'd30);
        check("b2b_last_d0", 64'(cdb_data[0]), 64'h20A);
        tick();
        check("b2b_idle", 64'(cdb_count), 64'd0);

        // Squash with three pending and FU4 presenting.
        for (int i = 0; i < 3; i++) begin
            fu_valid[i] = 1'b1;
            fu_tag[i]   = PR'(40 + i);
            fu_data[i]  = XLEN'(32'h400 + i);
        end
        tick();
        idle_inputs();
        fu_valid[4] = 1'b1;
        fu_tag[4]   = 6'd44;
        fu_data[4]  = 32'h444;
        squash      = 1'b1;
        tick();
        idle_inputs();
        check("sq_count", 64'(cdb_count), 64'd0);
        check("sq_t0", 64'(cdb_t0), 64'd0);
        check("sq_ready", 64'(fu_ready), 64'h1f);
        tick();
        check("sq_after_count", 64'(cdb_count), 64'd0);
        check("sq_after_t0", 64'(cdb_t0), 64'd0);

        // Asynchronous reset mid-cycle with holding registers occupied.
        load_all(1);
        tick();
        idle_inputs();
        tick();
        check("rst_pre_count", 64'(cdb_count), 64'd3);
        #2;
        reset = 1'b1;
        #1;
        check("rst_async_count", 64'(cdb_count), 64'd0);
        check("rst_async_t0", 64'(cdb_t0), 64'd0);
        check("rst_async_t2", 64'(cdb_t2), 64'd0);
        check("rst_async_d0", 64'(cdb_data[0]), 64'h0);
        check("rst_async_ready", 64'(fu_ready), 64'h1f);
        tick();
        reset = 1'b0;
        tick();
        check("rst_after_count", 64'(cdb_count), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts_evaluated, failures);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Writeback/completion stage sitting directly upstream of the physical register file.
- Collects results from NUM_FU functional units, each through a one-entry holding register.
- Each cycle, selects up to 3 results by rotating priority and drives them as a registered 3-wide broadcast: three tags plus three data words.
- The broadcast feeds the regfile write port (tag fields t0/t1/t2 with matching wr_data[0..2]), reservation-station wakeup and ROB completion.

Parameters:
- NUM_FU, 5, number of functional-unit result sources (range 3..8).
- PR, `PR, physical register index width.
- XLEN, `XLEN, data word width.
- ZERO_PR, `ZERO_PR, tag meaning "no write" (the hardwired-zero register).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- squash  in  1  pipeline flush (branch mispredict/exception), synchronous.
- fu_valid  in  NUM_FU  result valid per FU.
- fu_tag  in  NUM_FU x PR  destination physical register per FU.
- fu_data  in  NUM_FU x XLEN  result value per FU.
- fu_ready  out  NUM_FU  holding register can accept this cycle.
- cdb_t0, cdb_t1, cdb_t2  out  PR each  broadcast tags; ZERO_PR marks an idle slot.
- cdb_data  out  3 x XLEN  data for slots 0/1/2.
- cdb_count  out  2  number of non-idle slots (0..3).

Behaviour:
- Reset (async, immediate):
  - all hold_valid cleared; rr_ptr=0.
  - cdb_t0/t1/t2=ZERO_PR; cdb_data=0; cdb_count=0.
  - fu_ready goes to all 1s combinationally.
- Accept:
  - Occurs at the rising edge where fu_valid[i] && fu_ready[i] is true.
  - Loads hold_tag[i], hold_data[i] and sets hold_valid[i].
  - If fu_tag[i]==ZERO_PR, the result is consumed and discarded: no hold, never broadcast.
- Ready: fu_ready[i] = !hold_valid[i] || grant[i]. A holding register freed by a grant accepts new data on the same edge.
- Selection (combinational from hold regs):
  - Scan FUs in order rr_ptr, rr_ptr+1, ... mod NUM_FU.
  - The first three with hold_valid set are granted, filling slot 0, then 1, then 2.
  - Unfilled slots are idle.
- Broadcast: granted tag/data are registered into cdb_* at the same edge the grant clears hold_valid.
- Latency:
  - A result accepted at edge k is eligible in the next cycle.
  - If granted, it is visible on cdb_* after edge k+1 for exactly one cycle.
  - Minimum latency is 2 edges; there is no bypass.
- Round robin:
  - If at least one grant, rr_ptr <= (index of last granted FU + 1) mod NUM_FU.
  - If no grant, rr_ptr is unchanged.
  - Guarantees every holding register is granted within ceil(NUM_FU/3) cycles.
- Squash (sync, highest priority):
  - At the edge, all hold_valid are cleared; fu_valid in that cycle is ignored.
  - cdb_* load idle values (ZERO_PR tags, zero data, count 0).
  - rr_ptr is unchanged.
- Idle output: when no hold_valid is set, cdb_* carry idle values on the next edge. There is never a stale repeat of the previous broadcast.
- Duplicate tags: no checking. Two FUs carrying the same non-zero tag are both broadcast; the higher slot wins in the regfile. The issue logic guarantees this never occurs.
- Throughput: at most 3 results per cycle. When more than 3 are pending, the excess stay held and fu_ready drops for those FUs until granted.
- Reset mid-operation: pending results are lost; outputs go idle immediately, with no clock edge needed.

Test Plan:
- Reset/idle: assert reset asynchronously mid-cycle with hold regs full.
  - Required: cdb tags=ZERO_PR, data=0, count=0 immediately.
  - Required: fu_ready=all 1s.
- Single result: FU2 presents tag=7, data=0xDEAD at edge 1.
  - Required: cdb_t0=7, cdb_data[0]=0xDEAD, count=1 after edge 2.
  - Required: idle again after edge 3.
- Overflow/fairness: all 5 FUs present tags 1..5 at the same edge, rr_ptr=0.
  - Required next broadcast: tags 1,2,3 in slots 0,1,2, fu_ready[3:4]=0.
  - Required following broadcast: tags 4,5, with rr_ptr=0 afterward.
- Zero tag: FU0 presents tag=ZERO_PR, data=0x55.
  - Required: fu_ready[0] stays 1, nothing is broadcast, count stays 0.
- Back-to-back: FU1 holds valid and is granted; FU1 presents a new result on the same edge.
  - Required: the new result is accepted and broadcast on the following cycle.
  - Required: continuous 1-per-cycle stream for 10 cycles with no bubbles.
- Squash: three results pending plus FU4 valid; assert squash for one cycle.
  - Required: next cdb idle, all holds empty, FU4 result dropped.
  - Required: fu_ready all 1s.
